// File: rtl/eight_demux_deser.sv
// 1:8 demultiplexing deserializer: steers one WIDTH-bit word per handshake into lanes 0..7 and
// presents the assembled frame on a registered valid/ready output. Optional DEMUX_PARITY_EN adds out_parity.
module eight_demux_deser #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [2:0]         lane_sel,
`ifdef DEMUX_PARITY_EN
   output logic               out_parity,
`endif
   output logic               busy
);

   // Lane 7 is never stored: the completing beat goes straight into out_data.
   logic [6:0][WIDTH-1:0] lane_q;
   logic                  accept;
   logic                  last_lane;

   assign last_lane = (lane_sel == 3'd7);
   assign in_ready  = !flush && !(last_lane && out_valid && !out_ready);
   assign accept    = in_valid && in_ready;
   assign busy      = (lane_sel != 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q    <= '0;
         lane_sel  <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (flush) begin
            lane_sel <= 3'd0;
         end else if (accept) begin
            lane_sel <= lane_sel + 3'd1;
         end

         if (accept) begin
            for (int k = 0; k < 7; k++) begin
               if (lane_sel == 3'(k)) begin
                  lane_q[k] <= in_data;
               end
            end
         end

         // A completing beat overrides a same-cycle drain, giving zero-bubble throughput.
         if (accept && last_lane) begin
            out_data  <= {in_data, lane_q};
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef DEMUX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_parity <= 1'b0;
      end else if (accept && last_lane) begin
         out_parity <= ^{in_data, lane_q};
      end
   end
`endif

endmodule

// File: tb/tb_eight_demux_deser.sv
// Randomized and directed bench for eight_demux_deser (WIDTH=8) against a frame-level reference model.
module tb_eight_demux_deser;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [8*W-1:0] out_data;
   logic [2:0]     lane_sel;
   logic           busy;
`ifdef DEMUX_PARITY_EN
   logic           out_parity;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // reference model: beats collected so far, pending frame
   int             m_sel;
   logic [7:0]     m_lane [8];
   logic           m_ov;
   logic [63:0]    m_od;

   eight_demux_deser #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .lane_sel  (lane_sel),
`ifdef DEMUX_PARITY_EN
      .out_parity(out_parity),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sel = 0;
      m_ov  = 1'b0;
      m_od  = '0;
      for (int k = 0; k < 8; k++) m_lane[k] = '0;
   endtask

   // Called at a falling edge with inputs applied; checks, advances the model, waits one cycle.
   task automatic tick();
      bit rdy, acc, done;
      #1;
      rdy = !flush && !(m_sel == 7 && m_ov && !out_ready);
      chk("in_ready",  64'(in_ready),  64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data",  out_data,       m_od);
      chk("lane_sel",  64'(lane_sel),  64'(m_sel));
      chk("busy",      64'(busy),      64'(m_sel != 0));
`ifdef DEMUX_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'(^m_od));
`endif
      acc  = in_valid && rdy;
      done = acc && (m_sel == 7);
      if (acc) m_lane[m_sel] = in_data;
      if (done) begin
         for (int k = 0; k < 8; k++) m_od[k*8 +: 8] = m_lane[k];
         m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      if (flush) m_sel = 0;
      else if (acc) m_sel = (m_sel + 1) % 8;
      @(negedge clk);
   endtask

   task automatic beat(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic mid_reset();
      #3 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_lane_sel",  64'(lane_sel),  64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      // T1: reset state
      #1;
      chk("t1_out_valid", 64'(out_valid), 64'd0);
      chk("t1_out_data",  out_data,       64'd0);
      chk("t1_lane_sel",  64'(lane_sel),  64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      chk("t1_busy",     64'(busy),     64'd0);
      @(negedge clk);

      // T2: back-to-back frame with consumer ready
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) beat(8'(i));
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_frame", out_data, 64'h0807060504030201);
      tick();
      chk("t2_valid_drop", 64'(out_valid), 64'd0);

      // T3: back-pressure, only the 8th beat of frame 2 stalls
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) beat(8'(i));
      chk("t3_frame1", out_data, 64'h0706050403020100);
      in_valid = 1'b1;
      in_data  = 8'h0F;
      #1;
      chk("t3_stall", 64'(in_ready), 64'd0);
      @(negedge clk);
      tick();
      tick();
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("t3_frame2", out_data, 64'h0F0E0D0C0B0A0908);
      chk("t3_valid2", 64'(out_valid), 64'd1);
      tick();
      out_ready = 1'b1;
      tick();

      // T4: flush drops partial frame and the in-flight beat
      beat(8'hAA);
      beat(8'hBB);
      beat(8'hCC);
      flush = 1'b1;
      beat(8'hDD);
      flush = 1'b0;
      chk("t4_sel", 64'(lane_sel), 64'd0);
      for (int i = 0; i < 8; i++) beat(8'hA0 + 8'(i));
      chk("t4_frame", out_data, 64'hA7A6A5A4A3A2A1A0);
      tick();

      // T5: reset mid-frame with a pending frame
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) beat(8'h50 + 8'(i));
      for (int i = 0; i < 5; i++) beat(8'h60 + 8'(i));
      mid_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) beat(8'h10 + 8'(i));
      chk("t5_frame", out_data, 64'h1716151413121110);
      tick();

`ifdef DEMUX_PARITY_EN
      // T6: parity
      for (int i = 0; i < 8; i++) beat(8'h01);
      chk("t6_par0", 64'(out_parity), 64'd0);
      for (int i = 0; i < 8; i++) beat((i == 3) ? 8'h03 : 8'h01);
      chk("t6_par1", 64'(out_parity), 64'd1);
      tick();
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         tick();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
